// File: rtl/maxmin_arb_if.sv
// Handshake and result bundle between the two sample producers and maxmin_arb.
// master = producer/consumer side, slave = the arbiter.
interface maxmin_arb_if #(
  parameter int W = 16
);
  logic         req0;
  logic         req1;
  logic         vld0;
  logic         vld1;
  logic [W-1:0] din0;
  logic [W-1:0] din1;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] max_out;
  logic [W-1:0] min_out;
  logic         owner;
  logic         rdy;
  logic         busy;

  modport master (
    output req0, req1, vld0, vld1, din0, din1,
    input  gnt0, gnt1, max_out, min_out, owner, rdy, busy
  );

  modport slave (
    input  req0, req1, vld0, vld1, din0, din1,
    output gnt0, gnt1, max_out, min_out, owner, rdy, busy
  );
endinterface

// File: rtl/maxmin_arb.sv
// Two-requester round-robin frame scheduler sharing one signed max/min tracker.
// Publishes each completed frame's max/min/owner with a one-cycle rdy pulse.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests
// RUN   | owner streams samples into the accumulators
// DONE  | single rdy cycle; results were published on entry
module maxmin_arb #(
  parameter int W  = 16,
  parameter int N  = 16,
  parameter int CW = 4
) (
  input logic         clk,
  input logic         rst,
  maxmin_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                cur, cur_nxt;
  logic                last_owner, last_nxt;
  logic                gnt0_nxt, gnt1_nxt;
  logic                pub;
  logic [CW-1:0]       count, count_nxt;
  logic signed [W-1:0] acc_max, acc_min;
  logic signed [W-1:0] acc_max_nxt, acc_min_nxt;
  logic signed [W-1:0] smp;
  logic                own_req, own_vld, pick, final_smp;

  assign own_req   = cur ? bus.req1 : bus.req0;
  assign own_vld   = cur ? bus.vld1 : bus.vld0;
  assign smp       = $signed(cur ? bus.din1 : bus.din0);
  // A tie goes to whoever did not own the datapath last.
  assign pick      = (bus.req0 & bus.req1) ? ~last_owner : bus.req1;
  assign final_smp = (count == CW'(N - 1));

  assign bus.rdy  = (state == DONE);
  assign bus.busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    last_nxt    = last_owner;
    gnt0_nxt    = 1'b0;
    gnt1_nxt    = 1'b0;
    count_nxt   = count;
    acc_max_nxt = acc_max;
    acc_min_nxt = acc_min;
    pub         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_nxt = RUN;
          cur_nxt   = pick;
          gnt0_nxt  = ~pick;
          gnt1_nxt  = pick;
          count_nxt = '0;
        end
      end
      RUN: begin
        if (!own_req) begin
          // Abort: drop the partial frame but remember who had the turn.
          state_nxt = IDLE;
          last_nxt  = cur;
        end else begin
          gnt0_nxt = bus.gnt0;
          gnt1_nxt = bus.gnt1;
          if (own_vld) begin
            if (count == '0) begin
              acc_max_nxt = smp;
              acc_min_nxt = smp;
            end else begin
              acc_max_nxt = (smp > acc_max) ? smp : acc_max;
              acc_min_nxt = (smp < acc_min) ? smp : acc_min;
            end
            count_nxt = count + CW'(1);
            if (final_smp) begin
              state_nxt = DONE;
              gnt0_nxt  = 1'b0;
              gnt1_nxt  = 1'b0;
              last_nxt  = cur;
              pub       = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= 1'b0;
      last_owner  <= 1'b1;
      count       <= '0;
      acc_max     <= '0;
      acc_min     <= '0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.max_out <= '0;
      bus.min_out <= '0;
      bus.owner   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      last_owner <= last_nxt;
      count      <= count_nxt;
      acc_max    <= acc_max_nxt;
      acc_min    <= acc_min_nxt;
      bus.gnt0   <= gnt0_nxt;
      bus.gnt1   <= gnt1_nxt;
      if (pub) begin
        bus.max_out <= acc_max_nxt;
        bus.min_out <= acc_min_nxt;
        bus.owner   <= cur;
      end
    end
  end

endmodule

// File: tb/tb_maxmin_arb.sv
// Randomized bench for maxmin_arb: a frame-level reference model plus
// directed frames with hand-computed results.
module tb_maxmin_arb;
  localparam int W  = 16;
  localparam int N  = 16;
  localparam int CW = 4;

  typedef int frame_t[N];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxmin_arb_if #(.W(W)) bus ();
  maxmin_arb #(.W(W), .N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the datapath, the samples collected so far,
  // and the last published frame result.
  int m_phase, m_own, m_last;
  int q[$];
  int e_max, e_min, e_owner;
  int d, mx, mn;
  bit r, v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_own = 0; m_last = 1;
      q.delete();
      e_max = 0; e_min = 0; e_owner = 0;
    end else begin
      case (m_phase)
        0: if (bus.req0 || bus.req1) begin
             if (bus.req0 && bus.req1) m_own = 1 - m_last;
             else m_own = bus.req1 ? 1 : 0;
             q.delete();
             m_phase = 1;
           end
        1: begin
             r = m_own ? bus.req1 : bus.req0;
             v = m_own ? bus.vld1 : bus.vld0;
             d = m_own ? int'($signed(bus.din1)) : int'($signed(bus.din0));
             if (!r) begin
               m_last = m_own;
               m_phase = 0;
             end else if (v) begin
               q.push_back(d);
               if (q.size() == N) begin
                 mx = q[0]; mn = q[0];
                 foreach (q[i]) begin
                   if (q[i] > mx) mx = q[i];
                   if (q[i] < mn) mn = q[i];
                 end
                 e_max = mx; e_min = mn; e_owner = m_own;
                 m_last = m_own;
                 m_phase = 2;
               end
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  int g0cnt = 0;
  int cyc_no = 0;
  int rdy_own[$], rdy_max[$], rdy_min[$], rdy_cyc[$];

  always @(negedge clk) begin
    cyc_no++;
    if (!rst) begin
      chk("gnt0", bus.gnt0, (m_phase == 1 && m_own == 0));
      chk("gnt1", bus.gnt1, (m_phase == 1 && m_own == 1));
      chk("busy", bus.busy, (m_phase != 0));
      chk("rdy", bus.rdy, (m_phase == 2));
      chk("max_out", $signed(bus.max_out), e_max);
      chk("min_out", $signed(bus.min_out), e_min);
      chk("owner", bus.owner, e_owner);
      if (bus.gnt0) g0cnt++;
      if (bus.rdy) begin
        rdy_own.push_back(bus.owner);
        rdy_max.push_back($signed(bus.max_out));
        rdy_min.push_back($signed(bus.min_out));
        rdy_cyc.push_back(cyc_no);
      end
    end
  end

  task automatic set_req(input int who, input bit b);
    if (who != 0) bus.req1 = b; else bus.req0 = b;
  endtask
  task automatic set_vld(input int who, input bit b);
    if (who != 0) bus.vld1 = b; else bus.vld0 = b;
  endtask
  task automatic set_din(input int who, input int val);
    if (who != 0) bus.din1 = W'(val); else bus.din0 = W'(val);
  endtask
  function automatic bit granted(input int who);
    return (who != 0) ? bus.gnt1 : bus.gnt0;
  endfunction

  // Requests the datapath and streams vals once granted; returns after
  // stop_at accepts. keep=1 leaves req/vld asserted (used for mid-frame reset).
  task automatic run_frame(input int who, input frame_t vals, input bit bubble,
                           input int stop_at, input bit keep);
    int idx = 0;
    int cyc = 0;
    bit done = 0;
    bit pre_g, pre_v;
    set_req(who, 1'b1);
    set_vld(who, 1'b0);
    while (!done && cyc < 400) begin
      pre_g = granted(who);
      pre_v = (who != 0) ? bus.vld1 : bus.vld0;
      @(posedge clk); #2;
      cyc++;
      if (pre_g && pre_v) idx++;
      if (idx == stop_at) begin
        if (!keep) begin
          set_req(who, 1'b0);
          set_vld(who, 1'b0);
        end
        done = 1;
      end else if (granted(who)) begin
        set_vld(who, bubble ? bit'(cyc % 2) : 1'b1);
        set_din(who, vals[idx]);
      end else begin
        set_vld(who, bit'($urandom % 2));
        set_din(who, int'($urandom));
      end
    end
    if (!done) chk("frame_timeout", idx, stop_at);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  frame_t alt, alt_neg, bub, m5, ra, rb;
  int n0, stop0, stop1, mask, dl0, dl1;
  bit b0, b1;

  initial begin
    for (int i = 0; i < N; i++) begin
      alt[i]     = (i % 2 == 0) ? (i + 1) : -(i + 1);
      alt_neg[i] = -alt[i];
      bub[i]     = 7;
      m5[i]      = -5;
    end
    bub[3]  = -32768;
    bub[10] = 32767;

    bus.req0 = 0; bus.req1 = 0; bus.vld0 = 0; bus.vld1 = 0;
    bus.din0 = '0; bus.din1 = '0;
    rst = 1;
    idle_cycles(2);
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_rdy", bus.rdy, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_max", $signed(bus.max_out), 0);
    chk("rst_min", $signed(bus.min_out), 0);
    chk("rst_owner", bus.owner, 0);
    rst = 0;
    idle_cycles(1);

    // single frame from requester 0
    g0cnt = 0;
    n0 = rdy_own.size();
    run_frame(0, alt, 1'b0, N, 1'b0);
    idle_cycles(2);
    chk("single_rdy_count", rdy_own.size() - n0, 1);
    chk("single_max", $signed(bus.max_out), 15);
    chk("single_min", $signed(bus.min_out), -16);
    chk("single_owner", bus.owner, 0);
    chk("single_gnt0_cycles", g0cnt, 16);

    // contention from a fresh tie: requester 0 wins, then requester 1
    rst = 1; idle_cycles(1); rst = 0; idle_cycles(1);
    n0 = rdy_own.size();
    fork
      run_frame(0, alt, 1'b0, N, 1'b0);
      run_frame(1, alt_neg, 1'b0, N, 1'b0);
    join
    idle_cycles(2);
    chk("cont_rdy_count", rdy_own.size() - n0, 2);
    if (rdy_own.size() - n0 == 2) begin
      chk("cont_own_a", rdy_own[n0], 0);
      chk("cont_max_a", rdy_max[n0], 15);
      chk("cont_min_a", rdy_min[n0], -16);
      chk("cont_own_b", rdy_own[n0+1], 1);
      chk("cont_max_b", rdy_max[n0+1], 16);
      chk("cont_min_b", rdy_min[n0+1], -15);
      chk("cont_spacing", rdy_cyc[n0+1] - rdy_cyc[n0], N + 2);
    end

    // bubbles on the owner, noise on the idle requester
    n0 = rdy_own.size();
    fork
      run_frame(0, bub, 1'b1, N, 1'b0);
      repeat (40) begin
        @(posedge clk); #2;
        bus.vld1 = bit'($urandom % 2);
        bus.din1 = W'($urandom);
      end
    join
    bus.vld1 = 0;
    idle_cycles(2);
    chk("bub_rdy_count", rdy_own.size() - n0, 1);
    chk("bub_max", $signed(bus.max_out), 32767);
    chk("bub_min", $signed(bus.min_out), -32768);
    chk("bub_owner", bus.owner, 0);

    // abort by requester 1, then a tie must go to requester 0
    for (int i = 0; i < N; i++) rb[i] = int'($signed(W'($urandom)));
    n0 = rdy_own.size();
    run_frame(1, rb, 1'b0, 5, 1'b0);
    idle_cycles(2);
    chk("abort_gnt1", bus.gnt1, 0);
    chk("abort_no_rdy", rdy_own.size() - n0, 0);
    chk("abort_max_kept", $signed(bus.max_out), 32767);
    chk("abort_min_kept", $signed(bus.min_out), -32768);
    fork
      run_frame(0, m5, 1'b0, N, 1'b0);
      run_frame(1, rb, 1'b0, N, 1'b0);
    join
    idle_cycles(2);
    chk("tie_rdy_count", rdy_own.size() - n0, 2);
    if (rdy_own.size() - n0 == 2) begin
      chk("tie_first_owner", rdy_own[n0], 0);
      chk("equal_max", rdy_max[n0], -5);
      chk("equal_min", rdy_min[n0], -5);
      chk("tie_second_owner", rdy_own[n0+1], 1);
    end

    // asynchronous reset in the middle of a frame
    run_frame(0, alt, 1'b0, 8, 1'b1);
    #1 rst = 1;
    #1;
    chk("arst_gnt0", bus.gnt0, 0);
    chk("arst_rdy", bus.rdy, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_max", $signed(bus.max_out), 0);
    chk("arst_min", $signed(bus.min_out), 0);
    bus.req0 = 0; bus.vld0 = 0;
    idle_cycles(1);
    rst = 0;
    idle_cycles(1);
    run_frame(0, alt, 1'b0, N, 1'b0);
    idle_cycles(2);
    chk("post_rst_max", $signed(bus.max_out), 15);
    chk("post_rst_min", $signed(bus.min_out), -16);
    chk("post_rst_owner", bus.owner, 0);

    // randomized traffic, occasional aborts, checked by the model every cycle
    repeat (10) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = int'($signed(W'($urandom)));
        rb[i] = int'($signed(W'($urandom)));
      end
      mask  = $urandom_range(1, 3);
      b0    = bit'($urandom % 2);
      b1    = bit'($urandom % 2);
      stop0 = ($urandom % 4 == 0) ? $urandom_range(1, N - 1) : N;
      stop1 = ($urandom % 4 == 0) ? $urandom_range(1, N - 1) : N;
      dl0   = $urandom_range(0, 3);
      dl1   = $urandom_range(0, 3);
      fork
        if (mask[0]) begin idle_cycles(dl0); run_frame(0, ra, b0, stop0, 1'b0); end
        if (mask[1]) begin idle_cycles(dl1); run_frame(1, rb, b1, stop1, 1'b0); end
      join
      idle_cycles(2);
    end

    idle_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
